seg_capture: RTL

SEG_CAPTURE -- requirements
Module: seg_capture

---
 rtl/seg_capture.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/seg_capture.sv
// seg_capture: recovers a 4-digit number by watching the multiplexed anode and
// segment lines of a common 4-digit 7-segment display.
// A digit is accepted once its anode/segment pattern has stayed steady for
// STABLE_CYCLES synchronized cycles. When all four digit slots of a frame are
// filled, the value is published on bcd_num together with a num_valid pulse.
// Ports:
//   clk        clock, all logic on the rising edge
//   rst_n      synchronous active-low reset
//   an[3:0]    active-low anodes; an[i] low selects digit i
//   seg[6:0]   active-low segment lines
//   bcd_num    last complete captured value, digit i in bits [4i+3:4i]
//   num_valid  one-cycle pulse when bcd_num is updated
//   err        one-cycle pulse on a protocol or decode error
module seg_capture #(
    parameter int unsigned STABLE_CYCLES = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  an,
    input  logic [6:0]  seg,
    output logic [15:0] bcd_num,
    output logic        num_valid,
    output logic        err
);
    localparam int unsigned CNT_W = $clog2(STABLE_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRACK = 2'd1,
        HELD  = 2'd2
    } state_t;

    logic [3:0]       r_an_s1, r_an_s2, r_an_prev;
    logic [6:0]       r_seg_s1, r_seg_s2, r_seg_prev;
    state_t           r_state, w_state_next;
    logic [CNT_W-1:0] r_cnt, w_cnt_next;
    logic [3:0]       r_mask, w_mask_next;
    logic [15:0]      r_slots;
    logic [15:0]      r_bcd;
    logic             r_valid, r_err;

    logic             w_change, w_one_low, w_multi, w_prev_multi;
    logic             w_accept, w_multi_err, w_code_ok, w_err_evt;
    logic [3:0]       w_nibble;
    logic [1:0]       w_idx;

    // Number of asserted (low) anode lines
    function automatic logic [2:0] low_count(input logic [3:0] a);
        return 3'(~a[0]) + 3'(~a[1]) + 3'(~a[2]) + 3'(~a[3]);
    endfunction

    assign w_change     = (r_an_s2 != r_an_prev) || (r_seg_s2 != r_seg_prev);
    assign w_one_low    = (low_count(r_an_s2) == 3'd1);
    assign w_multi      = (low_count(r_an_s2) >= 3'd2);
    assign w_prev_multi = (low_count(r_an_prev) >= 3'd2);
    // Error only on the cycle a multi-anode pattern is entered
    assign w_multi_err  = w_multi && !w_prev_multi;
    assign w_err_evt    = w_multi_err || (w_accept && !w_code_ok);

    // Position of the single low anode
    always_comb begin
        w_idx = 2'd0;
        case (r_an_s2)
            4'b1110: w_idx = 2'd0;
            4'b1101: w_idx = 2'd1;
            4'b1011: w_idx = 2'd2;
            4'b0111: w_idx = 2'd3;
            default: w_idx = 2'd0;
        endcase
    end

    // Segment pattern to BCD digit
    always_comb begin
        w_nibble  = 4'd0;
        w_code_ok = 1'b1;
        case (r_seg_s2)
            7'h40:   w_nibble = 4'd0;
            7'h79:   w_nibble = 4'd1;
            7'h24:   w_nibble = 4'd2;
            7'h30:   w_nibble = 4'd3;
            7'h19:   w_nibble = 4'd4;
            7'h12:   w_nibble = 4'd5;
            7'h02:   w_nibble = 4'd6;
            7'h78:   w_nibble = 4'd7;
            7'h00:   w_nibble = 4'd8;
            7'h10:   w_nibble = 4'd9;
            default: w_code_ok = 1'b0;
        endcase
    end

    // Next-state logic: stability tracking and accept decision
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_accept     = 1'b0;
        if (w_multi) begin
            w_state_next = IDLE;
            w_cnt_next   = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_one_low) begin
                        w_state_next = TRACK;
                        w_cnt_next   = CNT_W'(1);
                    end
                end
                TRACK: begin
                    if (w_change) begin
                        w_state_next = w_one_low ? TRACK : IDLE;
                        w_cnt_next   = w_one_low ? CNT_W'(1) : '0;
                    end else begin
                        if (r_cnt != CNT_W'(STABLE_CYCLES)) begin
                            w_cnt_next = r_cnt + CNT_W'(1);
                        end
                        if (r_cnt == CNT_W'(STABLE_CYCLES - 1)) begin
                            w_accept     = 1'b1;
                            w_state_next = HELD;
                        end
                    end
                end
                HELD: begin
                    if (w_change) begin
                        w_state_next = w_one_low ? TRACK : IDLE;
                        w_cnt_next   = w_one_low ? CNT_W'(1) : '0;
                    end
                end
                default: begin
                    w_state_next = IDLE;
                    w_cnt_next   = '0;
                end
            endcase
        end
    end

    // Frame mask: completion clears, accept sets, error clear wins
    always_comb begin
        w_mask_next = (r_mask == 4'hF) ? 4'h0 : r_mask;
        if (w_accept && w_code_ok) begin
            w_mask_next[w_idx] = 1'b1;
        end
        if (w_err_evt) begin
            w_mask_next = 4'h0;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Synchronizers, digit slots and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_an_s1    <= 4'hF;
            r_an_s2    <= 4'hF;
            r_an_prev  <= 4'hF;
            r_seg_s1   <= 7'h7F;
            r_seg_s2   <= 7'h7F;
            r_seg_prev <= 7'h7F;
            r_mask     <= 4'h0;
            r_slots    <= 16'h0;
            r_bcd      <= 16'h0;
            r_valid    <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_an_s1    <= an;
            r_an_s2    <= r_an_s1;
            r_an_prev  <= r_an_s2;
            r_seg_s1   <= seg;
            r_seg_s2   <= r_seg_s1;
            r_seg_prev <= r_seg_s2;
            r_mask     <= w_mask_next;
            r_valid    <= (r_mask == 4'hF);
            r_err      <= w_err_evt;
            if (r_mask == 4'hF) begin
                r_bcd <= r_slots;
            end
            if (w_accept && w_code_ok) begin
                r_slots[{w_idx, 2'b00} +: 4] <= w_nibble;
            end
        end
    end

    assign bcd_num   = r_bcd;
    assign num_valid = r_valid;
    assign err       = r_err;

endmodule
